// File: rtl/mem_access_unit.sv
// Load/store front end for a word-organised data memory: read-modify-write sub-word stores and
// sign/zero-extended loads. Define MEM_RANGE_CHECK_EN to reject addresses beyond the DM window.
module mem_access_unit #(
  parameter int unsigned DM_AW     = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic             dm_we,
  output logic             dm_read,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_in_d,
  input  logic [31:0]      dm_out_d
);

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StDone} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        signed_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic [31:0] offset_q;
  logic        misaligned;
  logic        out_of_range;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] st_merge;
  logic        unused_off;

  assign offset_q   = addr_q - BASE_ADDR;
  assign unused_off = ^{offset_q[31:DM_AW+2], offset_q[1:0]};

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SzByte:  misaligned = 1'b0;
      SzHalf:  misaligned = req_addr[0];
      SzWord:  misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

`ifdef MEM_RANGE_CHECK_EN
  logic [31:0] req_off;
  assign req_off      = req_addr - BASE_ADDR;
  assign out_of_range = (req_off >> (DM_AW + 2)) != 32'd0;
`else
  // Upper address bits alias onto the DM window.
  assign out_of_range = 1'b0;
`endif

  // Lane extraction for loads and lane replacement for sub-word stores.
  always_comb begin
    ld_byte  = dm_out_d[{addr_q[1:0], 3'b000} +: 8];
    ld_half  = addr_q[1] ? dm_out_d[31:16] : dm_out_d[15:0];
    ld_data  = dm_out_d;
    st_merge = dm_out_d;
    case (size_q)
      SzByte: begin
        ld_data = signed_q ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
        st_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      SzHalf: begin
        ld_data = signed_q ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
        st_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: begin
        ld_data  = dm_out_d;
        st_merge = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      merged_q     <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            merged_q <= req_wdata;
            size_q   <= req_size;
            we_q     <= req_we;
            signed_q <= req_signed;
            if (misaligned || out_of_range) begin
              state_q      <= StDone;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (req_we && req_size == SzWord) begin
              state_q <= StWr;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: state_q <= StCap;
        StCap: begin
          if (we_q) begin
            merged_q <= st_merge;
            state_q  <= StWr;
          end else begin
            resp_rdata_q <= ld_data;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= StDone;
          end
        end
        StWr: begin
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // DM strobes are gated by reset so an interrupted operation never touches memory.
  assign req_ready  = rst_n && (state_q == StIdle);
  assign dm_read    = rst_n && (state_q == StRd);
  assign dm_we      = rst_n && (state_q == StWr);
  assign dm_addr    = (state_q == StRd || state_q == StCap || state_q == StWr) ?
                      offset_q[DM_AW+1:2] : '0;
  assign dm_in_d    = (state_q == StWr) ? merged_q : '0;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front end that sits directly upstream of the word-organised data memory (DM) and drives its we/read/addr/in_d pins. It converts MIPS-style lb/lbu/lh/lhu/lw/sb/sh/sw requests from the execute stage into word accesses. Sub-word stores are done as read-modify-write, and load data is extracted and sign/zero-extended. A single-outstanding valid/ready handshake upstream and a one-cycle response pulse make it a multi-cycle MEM stage.

Parameters:
DM_AW, 10, DM word-address width; dm_addr carries byte-address bits [DM_AW+1:2].
BASE_ADDR, 32'h0000_0000, byte address mapped to DM word 0; word index = (req_addr - BASE_ADDR)[DM_AW+1:2].

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
req_valid  in  1  request present
req_ready  out  1  unit idle, request accepted when req_valid&&req_ready
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result, valid with resp_valid; 0 for stores/errors
resp_err  out  1  request rejected (misaligned/range), valid with resp_valid
dm_we  out  1  DM write enable
dm_read  out  1  DM read enable
dm_addr  out  DM_AW  DM word address
dm_in_d  out  32  DM write data
dm_out_d  in  32  DM read data, valid the cycle after dm_read=1

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; resp_valid=0, resp_rdata=0, resp_err=0, all latched request regs 0. dm_we and dm_read are gated by rst_n so no DM access occurs during any cycle with rst_n=0, even mid-operation. Any in-flight request is dropped with no response.
- req_ready=1 only in IDLE (and not in reset). req_valid while busy is ignored; the requester holds it.
- On acceptance, addr/size/we/signed/wdata are latched. All later behaviour uses latched copies.
- Little-endian lanes: lane = addr[1:0]; lane 0 = bits[7:0]. Half lane = addr[1]; half 0 = bits[15:0].
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=11. Goes IDLE->DONE, resp_err=1, no DM access.
- States: IDLE, RD, CAP, WR, DONE.
- Word store: IDLE->WR->DONE. dm_we=1 in WR, dm_in_d=wdata. Accept T, write T+1, resp_valid T+2.
- Load: IDLE->RD->CAP->DONE. dm_read=1 in RD. In CAP, dm_out_d is sampled and the lane is extracted/extended into resp_rdata. Accept T, resp_valid T+3.
- Sub-word store: IDLE->RD->CAP->WR->DONE. In CAP, the old word is captured and only the target lane(s) are replaced from wdata[7:0]/[15:0]. In WR, dm_we=1 with the merged word. Accept T, resp_valid T+4; other bytes are unchanged.
- dm_addr holds the latched word index from RD through WR and is 0 in IDLE. dm_in_d is 0 outside WR.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata/resp_err hold until the next DONE. A new request can be accepted the cycle after DONE.
- dm_we and dm_read are never both 1.

Optional Feature:
MEM_RANGE_CHECK_EN.
- Defined: if (req_addr - BASE_ADDR) >= 2^(DM_AW+2), the request takes the error path (IDLE->DONE, resp_err=1, no DM access).
- Undefined: upper bits are ignored and addresses alias modulo DM size; resp_err comes only from misalignment.

Test Plan:
- sw addr=0x28 wdata=0x12345678 -> dm_we one cycle with dm_addr=10, dm_in_d=0x12345678, resp_valid 2 cycles after accept, resp_err=0.
- lw 0x28 after above -> dm_read at T+1, resp_rdata=0x12345678 at T+3; lb signed 0x2B -> 0x00000012; lh signed 0x28 -> 0x00005678; lbu 0x28 -> 0x00000078.
- sb 0x29 wdata=0xFFFFFF80 -> RD, CAP, then WR with dm_in_d=0x12348078, resp at T+4; lb signed 0x29 -> 0xFFFFFF80.
- lh 0x29, sw 0x2A, size=11 -> resp_err=1, resp_rdata=0, dm_we=dm_read=0 throughout, resp_valid at T+1.
- rst_n low during WR of an sb -> dm_we=0 that cycle, no resp_valid, req_ready=1 next cycle after rst_n high, word unchanged; req_valid held during a busy lw is accepted only after DONE.
- With MEM_RANGE_CHECK_EN, DM_AW=10: sw 0x1000 -> resp_err=1, no write. Without it: word 0 is written.
